// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: active-low row strobe, debounced single-key detect, key-code FIFO.
// Define KEYPAD_TELEPHONE_MAP_EN to remap codes through the 4x4 telephone layout.
module keypad_scan_fifo #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
`ifdef KEYPAD_TELEPHONE_MAP_EN
    localparam int CODE_W        = 4
`else
    localparam int CODE_W        = $clog2(ROWS*COLS)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   row_drive,
    input  logic [COLS-1:0]   col_sense,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              overflow
);
    // state    | meaning
    // SCAN     | stepping rows each tick, looking for a single low column
    // DEBOUNCE | candidate seen, counting consecutive matching ticks
    // PRESSED  | key accepted, row frozen, counting all-high ticks for release
    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

`ifdef KEYPAD_TELEPHONE_MAP_EN
    if (ROWS != 4 || COLS != 4) begin : g_bad_dims
        $error("KEYPAD_TELEPHONE_MAP_EN requires ROWS=4 and COLS=4");
    end

    function automatic logic [3:0] tel_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: tel_code = 4'd1;   4'h1: tel_code = 4'd2;
            4'h2: tel_code = 4'd3;   4'h3: tel_code = 4'd10;
            4'h4: tel_code = 4'd4;   4'h5: tel_code = 4'd5;
            4'h6: tel_code = 4'd6;   4'h7: tel_code = 4'd11;
            4'h8: tel_code = 4'd7;   4'h9: tel_code = 4'd8;
            4'hA: tel_code = 4'd9;   4'hB: tel_code = 4'd12;
            4'hC: tel_code = 4'd14;  4'hD: tel_code = 4'd0;
            4'hE: tel_code = 4'd15;  default: tel_code = 4'd13;
        endcase
    endfunction
`endif

    logic [COLS-1:0]   col_meta, col_sync;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [RW-1:0]     row_idx, next_row;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CW-1:0]     cand, col_idx;
    int                n_low;
    logic              single, all_high, push;
    logic [CODE_W-1:0] push_code;

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, pop, do_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_sense;
            col_sync <= col_meta;
        end
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    always_comb begin
        n_low   = 0;
        col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_sync[c]) begin
                n_low   = n_low + 1;
                col_idx = CW'(c);
            end
        end
    end

    assign single   = (n_low == 1);
    assign all_high = &col_sync;
    assign next_row = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);

    always_comb begin
        row_drive          = '1;
        row_drive[row_idx] = 1'b0;
    end

    always_comb begin
        push = 1'b0;
        if (tick && single) begin
            if (state == S_SCAN && DEBOUNCE_SCANS == 1)
                push = 1'b1;
            else if (state == S_DEBOUNCE && col_idx == cand && cnt == CNT_W'(DEBOUNCE_SCANS - 1))
                push = 1'b1;
        end
    end

`ifdef KEYPAD_TELEPHONE_MAP_EN
    assign push_code = tel_code(2'(row_idx), 2'(col_idx));
`else
    assign push_code = CODE_W'(int'(row_idx) * COLS + int'(col_idx));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_SCAN;
            row_idx  <= '0;
            cnt      <= '0;
            cand     <= '0;
            key_held <= 1'b0;
        end else if (tick) begin
            case (state)
                S_SCAN: begin
                    if (single) begin
                        cand <= col_idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_held <= 1'b1;
                            cnt      <= '0;
                            state    <= S_PRESSED;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= S_DEBOUNCE;
                        end
                    end else begin
                        row_idx <= next_row;
                    end
                end
                S_DEBOUNCE: begin
                    if (single && col_idx == cand) begin
                        if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            key_held <= 1'b1;
                            cnt      <= '0;
                            state    <= S_PRESSED;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt     <= '0;
                        row_idx <= next_row;
                        state   <= S_SCAN;
                    end
                end
                S_PRESSED: begin
                    // Any low column restarts the release count; only the row stays frozen.
                    if (all_high) begin
                        if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            key_held <= 1'b0;
                            cnt      <= '0;
                            row_idx  <= next_row;
                            state    <= S_SCAN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign key_valid = !empty;
    assign pop       = key_valid && key_ready;
    assign do_push   = push && (!full || pop);
    assign key_code  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_code;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            overflow <= push && full && !pop;
        end
    end
endmodule
